// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the icache request and
// feeds IF/ID through a one-entry skid buffer so a stalled fetch is never re-issued.
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          CPUID   = 0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] instr_out,
   output logic [31:0] pc_4_out,
   output logic        instr_valid,
   output logic [31:0] fetch_pc
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HALTED  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;
   assign fetch_pc = pc_q;
   // The PC only moves once the in-flight request returns, so pc_q is also the held address.
   assign imemaddr = pc_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= FETCH;
         pc_q        <= PC_INIT;
         buf_valid_q <= 1'b0;
         buf_instr_q <= 32'd0;
         buf_pc4_q   <= 32'd0;
         pend_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_valid_q <= buf_valid_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
         pend_pc_q   <= pend_pc_d;
      end
   end

   always_comb begin
      iREN        = 1'b0;
      instr_valid = 1'b0;
      instr_out   = 32'd0;
      pc_4_out    = 32'd0;
      state_d     = state_q;
      pc_d        = pc_q;
      buf_valid_d = buf_valid_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      pend_pc_d   = pend_pc_q;

      case (state_q)
         FETCH: begin
            iREN = !buf_valid_q;
            if (halt) begin
               state_d     = HALTED;
               buf_valid_d = 1'b0;
            end else if (redirect) begin
               buf_valid_d = 1'b0;
               if (ihit || buf_valid_q) begin
                  pc_d = redirect_pc;
               end else begin
                  // Miss in flight: keep the address stable until the icache answers.
                  pend_pc_d = redirect_pc;
                  state_d   = DISCARD;
               end
            end else if (buf_valid_q) begin
               instr_valid = 1'b1;
               instr_out   = buf_instr_q;
               pc_4_out    = buf_pc4_q;
               if (!stall) begin
                  buf_valid_d = 1'b0;
               end
            end else if (ihit) begin
               instr_valid = 1'b1;
               instr_out   = iload;
               pc_4_out    = pc_plus4;
               pc_d        = pc_plus4;
               if (stall) begin
                  buf_valid_d = 1'b1;
                  buf_instr_d = iload;
                  buf_pc4_d   = pc_plus4;
               end
            end
         end
         DISCARD: begin
            iREN = 1'b1;
            if (halt) begin
               state_d     = HALTED;
               buf_valid_d = 1'b0;
            end else if (ihit) begin
               state_d = FETCH;
               pc_d    = redirect ? redirect_pc : pend_pc_q;
            end else if (redirect) begin
               pend_pc_d = redirect_pc;
            end
         end
         HALTED: begin
            buf_valid_d = 1'b0;
         end
         default: begin
            state_d     = HALTED;
            buf_valid_d = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit (streaming, miss, skid buffer,
// redirect/discard, halt, reset, PC wrap).
`default_nettype none

module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit;
   logic [31:0] iload;
   logic        iREN;
   logic [31:0] imemaddr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] instr_out;
   logic [31:0] pc_4_out;
   logic        instr_valid;
   logic [31:0] fetch_pc;

   int total = 0;
   int bad   = 0;

   fetch_unit #(.PC_INIT(32'h0000_0000), .CPUID(0)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN),
      .imemaddr(imemaddr), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .instr_out(instr_out),
      .pc_4_out(pc_4_out), .instr_valid(instr_valid), .fetch_pc(fetch_pc)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic drive(input logic h, input logic [31:0] ld, input logic s,
                        input logic r, input logic [31:0] rpc, input logic hl);
      @(negedge CLK);
      ihit = h; iload = ld; stall = s; redirect = r; redirect_pc = rpc; halt = hl;
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
      nRST = 1'b0;
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; iload = 32'd0; stall = 1'b0;
      redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
      #2;
      chk("rst_iren",   {31'd0, iREN}, 32'd1);
      chk("rst_addr",   imemaddr, 32'h0);
      chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
      chk("rst_instr",  instr_out, 32'd0);
      chk("rst_pc4",    pc_4_out, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // 1: back-to-back hits
      drive(1, 32'hAAAA_0001, 0, 0, 0, 0);
      chk("t1_addr0", imemaddr, 32'h0);
      chk("t1_valid0", {31'd0, instr_valid}, 32'd1);
      chk("t1_instr0", instr_out, 32'hAAAA_0001);
      chk("t1_pc4_0", pc_4_out, 32'h4);
      drive(1, 32'hBBBB_0002, 0, 0, 0, 0);
      chk("t1_addr1", imemaddr, 32'h4);
      chk("t1_instr1", instr_out, 32'hBBBB_0002);
      chk("t1_pc4_1", pc_4_out, 32'h8);
      drive(1, 32'hCCCC_0003, 0, 0, 0, 0);
      chk("t1_addr2", imemaddr, 32'h8);
      chk("t1_instr2", instr_out, 32'hCCCC_0003);
      chk("t1_pc4_2", pc_4_out, 32'hC);

      // 2: three-cycle miss at 0x0
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
         chk("t2_miss_addr", imemaddr, 32'h0);
         chk("t2_miss_iren", {31'd0, iREN}, 32'd1);
         chk("t2_miss_valid", {31'd0, instr_valid}, 32'd0);
      end
      drive(1, 32'h1111_0000, 0, 0, 0, 0);
      chk("t2_hit_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_hit_pc4", pc_4_out, 32'h4);

      // 3: stall on hit at 0x10 fills the skid buffer
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h5A5A_5A5A, 1, 0, 0, 0);
      chk("t3_cap_addr", imemaddr, 32'h10);
      chk("t3_cap_valid", {31'd0, instr_valid}, 32'd1);
      chk("t3_cap_instr", instr_out, 32'h5A5A_5A5A);
      drive(0, 32'h0BAD_0BAD, 1, 0, 0, 0);
      chk("t3_buf_iren", {31'd0, iREN}, 32'd0);
      chk("t3_buf_fpc", fetch_pc, 32'h14);
      chk("t3_buf_instr", instr_out, 32'h5A5A_5A5A);
      chk("t3_buf_pc4", pc_4_out, 32'h14);
      chk("t3_buf_valid", {31'd0, instr_valid}, 32'd1);
      drive(0, 32'h0BAD_0BAD, 0, 0, 0, 0);
      chk("t3_cons_instr", instr_out, 32'h5A5A_5A5A);
      chk("t3_cons_iren", {31'd0, iREN}, 32'd0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t3_res_addr", imemaddr, 32'h14);
      chk("t3_res_iren", {31'd0, iREN}, 32'd1);
      chk("t3_res_valid", {31'd0, instr_valid}, 32'd0);

      // 4: redirect during a miss at 0x20
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(0, 32'h0, 0, 1, 32'h100, 0);
      chk("t4_redir_addr", imemaddr, 32'h20);
      chk("t4_redir_valid", {31'd0, instr_valid}, 32'd0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t4_disc_addr", imemaddr, 32'h20);
      chk("t4_disc_iren", {31'd0, iREN}, 32'd1);
      drive(1, 32'hFEED_FEED, 0, 0, 0, 0);
      chk("t4_drop_valid", {31'd0, instr_valid}, 32'd0);
      chk("t4_drop_instr", instr_out, 32'd0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t4_tgt_addr", imemaddr, 32'h100);
      chk("t4_tgt_iren", {31'd0, iREN}, 32'd1);

      // 5: redirect with hit, then redirect while buffer full
      drive(1, 32'h7777_7777, 0, 1, 32'h200, 0);
      chk("t5_hit_valid", {31'd0, instr_valid}, 32'd0);
      chk("t5_hit_instr", instr_out, 32'd0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t5_tgt_addr", imemaddr, 32'h200);
      drive(1, 32'h9999_9999, 1, 0, 0, 0);
      drive(0, 32'h0, 1, 1, 32'h300, 0);
      chk("t5_buf_valid", {31'd0, instr_valid}, 32'd0);
      chk("t5_buf_iren", {31'd0, iREN}, 32'd0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t5_clr_addr", imemaddr, 32'h300);
      chk("t5_clr_iren", {31'd0, iREN}, 32'd1);
      chk("t5_clr_valid", {31'd0, instr_valid}, 32'd0);

      // 6: halt beats redirect; HALTED ignores redirects
      drive(1, 32'h0, 0, 1, 32'h400, 1);
      chk("t6_halt_valid", {31'd0, instr_valid}, 32'd0);
      drive(1, 32'h0, 0, 1, 32'h500, 0);
      chk("t6_h_iren", {31'd0, iREN}, 32'd0);
      chk("t6_h_valid", {31'd0, instr_valid}, 32'd0);
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("t6_h_fpc", fetch_pc, 32'h300);
      chk("t6_h_iren2", {31'd0, iREN}, 32'd0);

      // 6b: reset in the middle of DISCARD drops the pending target
      pulse_reset();
      drive(1, 32'h0, 0, 0, 0, 0);
      drive(0, 32'h0, 0, 1, 32'h80, 0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t6_disc_addr", imemaddr, 32'h4);
      nRST = 1'b0;
      #1;
      chk("t6_rst_addr", imemaddr, 32'h0);
      chk("t6_rst_iren", {31'd0, iREN}, 32'd1);
      nRST = 1'b1;
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("t6_after_addr", imemaddr, 32'h0);

      // PC+4 wraps at the top of the address space
      drive(1, 32'h0, 0, 1, 32'hFFFF_FFFC, 0);
      drive(1, 32'h1234_5678, 0, 0, 0, 0);
      chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_4_out, 32'h0);
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("wrap_next", imemaddr, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID register bar. Owns the PC and runs the handshake with the instruction cache. Delivers instruction word plus PC+4 into the IF/ID inputs, and honours stall, redirect and halt requests from later stages. A one-entry skid buffer holds a fetched word during a stall so the instruction is never re-fetched.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
CPUID, 0, core index; carried for multicore builds, no functional effect in this block.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  icache returns valid iload for the current imemaddr this cycle.
iload  in  32  instruction word from icache.
iREN  out  1  instruction read request.
imemaddr  out  32  instruction fetch address.
stall  in  1  hazard unit: IF/ID must hold; no new instruction consumed this cycle.
redirect  in  1  taken branch, jump or JR resolved downstream; flush the fetch path.
redirect_pc  in  32  target address, valid with redirect.
halt  in  1  halt has reached writeback; stop fetching.
instr_out  out  32  instruction to IF/ID (instr_in_1); 0 when instr_valid=0.
pc_4_out  out  32  PC+4 of that instruction (pc_4_in_1); 0 when instr_valid=0.
instr_valid  out  1  instr_out/pc_4_out are a real instruction; IF/ID latches when instr_valid and !stall, else loads a bubble.
fetch_pc  out  32  current PC register, for debug and trace.

Behaviour:
- State machine states: FETCH, DISCARD, HALTED.
- Registers: pc, state, buf_valid, buf_instr, buf_pc4, pend_pc.
- Reset (async, nRST low) loads: pc=PC_INIT, state=FETCH, buf_valid=0, pend_pc=0.
- Values after reset: iREN=1, imemaddr=PC_INIT, instr_valid=0, instr_out=0, pc_4_out=0.
- imemaddr = pc in FETCH; held at the in-flight address in DISCARD.
- iREN = 1 in FETCH when buf_valid=0, and 1 in DISCARD; otherwise 0.
- Priority each cycle: halt > redirect > ihit/stall.
- FETCH, ihit, no redirect, no stall, buf empty:
  - instr_valid=1, instr_out=iload, pc_4_out=pc+4 (combinational, same cycle).
  - pc<=pc+4.
- FETCH, ihit and stall, no redirect, buf empty:
  - instr_valid=1 shown, but not consumed.
  - Capture buf_instr=iload, buf_pc4=pc+4, buf_valid<=1, pc<=pc+4.
- buf_valid=1:
  - Outputs come from the buffer, instr_valid=1, iREN=0.
  - First cycle with stall=0 consumes it: buf_valid<=0, and fetch resumes next cycle.
- FETCH, redirect:
  - buf_valid<=0; instr_valid=0 this cycle, so any ihit data is dropped.
  - If ihit, or iREN=0 (buffer held), or no request pending: pc<=redirect_pc, stay FETCH.
  - If iREN=1 and !ihit (miss in flight): pend_pc<=redirect_pc, go DISCARD; imemaddr held stable.
- DISCARD:
  - instr_valid=0 always.
  - On ihit: data dropped, pc<=pend_pc, go FETCH.
  - A new redirect overwrites pend_pc. Redirect together with ihit: pc<=redirect_pc.
- halt (any state): go HALTED, buf_valid<=0. HALTED is absorbing until reset; iREN=0, instr_valid=0, redirect ignored.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. redirect_pc is used as given, no alignment check.
- Reset mid-DISCARD or mid-buffer returns to reset values immediately; pending target and buffer are lost.

Test Plan:
1. Reset, ihit=1 every cycle, iload=A,B,C -> imemaddr 0x0,0x4,0x8; instr_valid=1; pc_4_out 0x4,0x8,0xC; instr_out A,B,C.
2. Miss: ihit low 3 cycles at pc 0x0 -> imemaddr holds 0x0, iREN=1, instr_valid=0; 4th cycle ihit -> instr_valid=1, pc_4_out=0x4.
3. stall=1 at ihit on pc 0x10 (iload=X) -> buffer captures; next cycles iREN=0, fetch_pc=0x14, instr_out=X, pc_4_out=0x14; stall drops -> consumed, next imemaddr=0x14.
4. Redirect to 0x100 while miss pending at 0x20 -> DISCARD, imemaddr stays 0x20; ihit 2 cycles later -> instr_valid=0, next imemaddr=0x100.
5. Redirect to 0x200 with ihit in same cycle, and redirect while buffer full -> no instruction valid that cycle, buffer cleared, next imemaddr=0x200.
6. halt with simultaneous redirect -> HALTED, iREN=0 thereafter despite further redirects; nRST pulse mid-DISCARD -> imemaddr=PC_INIT, iREN=1.
